nn_dense_seq: RTL and testbench



---
 rtl/nn_dense_seq.sv | 152 +++++++++++++++
 tb/tb_nn_dense_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_dense_seq.sv
// Sequential dense layer: one MAC per cycle over weights[i][j], then rescale,
// saturate, optional ReLU and a running argmax over the finalised outputs.
module nn_dense_seq #(
    parameter int N_INPUTS  = 4,
    parameter int N_OUTPUTS = 3,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 0,
    parameter int RELU_EN   = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [N_INPUTS-1:0][DATA_W-1:0]                in_vec,
    input  logic [N_INPUTS-1:0][N_OUTPUTS-1:0][DATA_W-1:0] weights,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [N_OUTPUTS-1:0][DATA_W-1:0]               out_vec,
    output logic [$clog2(N_OUTPUTS)-1:0]                   pred,
    output logic                                           sat
);
    localparam int I_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int J_W = $clog2(N_OUTPUTS);
    localparam logic [I_W-1:0] I_LAST = I_W'(N_INPUTS - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_OUTPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    // Returns {clipped, value} for a shifted accumulator.
    function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        if (v < SAT_MIN) return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        return {1'b0, v[DATA_W-1:0]};
    endfunction

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
        if ((RELU_EN != 0) && (v < 0)) return '0;
        return v;
    endfunction

    state_t                                state_q, state_d;
    logic signed [ACC_W-1:0]               acc_q, acc_d;
    logic [I_W-1:0]                        i_q, i_d;
    logic [J_W-1:0]                        j_q, j_d;
    logic [N_OUTPUTS-1:0][DATA_W-1:0]      out_vec_q, out_vec_d;
    logic [J_W-1:0]                        pred_q, pred_d;
    logic signed [DATA_W-1:0]              max_q, max_d;
    logic                                  sat_q, sat_d;
    logic [N_INPUTS-1:0][DATA_W-1:0]       in_reg_q;
    logic                                  load_in;

    logic signed [2*DATA_W-1:0]            a_ext, b_ext, prod;
    logic signed [ACC_W-1:0]               prod_ext, acc_sum, shifted;
    logic [DATA_W:0]                       sat_res;
    logic signed [DATA_W-1:0]              act;

    // Datapath: product of the current (i, j) pair and the finalised element value.
    always_comb begin
        a_ext    = (2*DATA_W)'($signed(in_reg_q[i_q]));
        b_ext    = (2*DATA_W)'($signed(weights[i_q][j_q]));
        prod     = a_ext * b_ext;
        prod_ext = ACC_W'(prod);
        acc_sum  = acc_q + prod_ext;
        shifted  = acc_sum >>> FRAC_BITS;
        sat_res  = saturate(shifted);
        act      = relu($signed(sat_res[DATA_W-1:0]));
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        i_d       = i_q;
        j_d       = j_q;
        out_vec_d = out_vec_q;
        pred_d    = pred_q;
        max_d     = max_q;
        sat_d     = sat_q;
        load_in   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_in = 1'b1;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    sat_d   = 1'b0;
                    max_d   = '0;
                    pred_d  = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (i_q == I_LAST) begin
                    out_vec_d[j_q] = act;
                    acc_d          = '0;
                    i_d            = '0;
                    if (sat_res[DATA_W]) sat_d = 1'b1;
                    // Strictly greater keeps the lowest index on ties.
                    if ((j_q == '0) || (act > max_q)) begin
                        max_d  = act;
                        pred_d = j_q;
                    end
                    if (j_q == J_LAST) state_d = OUT;
                    else               j_d     = j_q + 1'b1;
                end else begin
                    acc_d = acc_sum;
                    i_d   = i_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            out_vec_q <= '0;
            pred_q    <= '0;
            max_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            i_q       <= i_d;
            j_q       <= j_d;
            out_vec_q <= out_vec_d;
            pred_q    <= pred_d;
            max_q     <= max_d;
            sat_q     <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_in) in_reg_q <= in_vec;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_vec   = out_vec_q;
    assign pred      = pred_q;
    assign sat       = sat_q;
endmodule

// File: tb/tb_nn_dense_seq.sv
// Bench for nn_dense_seq: three instances (ReLU/no-ReLU/FRAC_BITS=8) share stimulus,
// expected results are queued at acceptance and checked when out_valid rises.
module tb_nn_dense_seq;
    typedef logic [3:0][15:0]       vin_t;
    typedef logic [3:0][2:0][15:0]  w_t;
    typedef logic [2:0][15:0]       vout_t;
    typedef struct packed {
        vout_t      vec;
        logic [1:0] pred;
        logic       sat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    vin_t       in_vec = '0;
    w_t         weights = '0;
    logic [2:0] in_ready, out_valid, sat;
    vout_t      out_vec [3];
    logic [1:0] pred [3];

    exp_t q0[$], q1[$], q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    nn_dense_seq #(.RELU_EN(1), .FRAC_BITS(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_vec(in_vec), .weights(weights), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_vec(out_vec[0]), .pred(pred[0]), .sat(sat[0]));
    nn_dense_seq #(.RELU_EN(0), .FRAC_BITS(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_vec(in_vec), .weights(weights), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_vec(out_vec[1]), .pred(pred[1]), .sat(sat[1]));
    nn_dense_seq #(.RELU_EN(0), .FRAC_BITS(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_vec(in_vec), .weights(weights), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_vec(out_vec[2]), .pred(pred[2]), .sat(sat[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int a, input int b, input int c, input int p, input bit s);
        exp_t e;
        e.vec[0] = 16'(a);
        e.vec[1] = 16'(b);
        e.vec[2] = 16'(c);
        e.pred   = 2'(p);
        e.sat    = s;
        return e;
    endfunction

    // Reference arithmetic for random vectors.
    function automatic exp_t model(input vin_t iv, input w_t wv, input bit relu_on, input int frac);
        exp_t    e;
        longint  acc, r, mx;
        e  = '0;
        mx = 0;
        for (int j = 0; j < 3; j++) begin
            acc = 0;
            for (int i = 0; i < 4; i++)
                acc += longint'($signed(iv[i])) * longint'($signed(wv[i][j]));
            r = acc >>> frac;
            if (r > 32767) begin r = 32767; e.sat = 1'b1; end
            else if (r < -32768) begin r = -32768; e.sat = 1'b1; end
            if (relu_on && r < 0) r = 0;
            e.vec[j] = 16'(r);
            if (j == 0 || r > mx) begin mx = r; e.pred = 2'(j); end
        end
        return e;
    endfunction

    task automatic push3(input exp_t a, input exp_t b, input exp_t c);
        q0.push_back(a);
        q1.push_back(b);
        q2.push_back(c);
    endtask

    task automatic set_in(input int a, input int b, input int c, input int d);
        in_vec[0] = 16'(a);
        in_vec[1] = 16'(b);
        in_vec[2] = 16'(c);
        in_vec[3] = 16'(d);
    endtask

    task automatic set_w_inc();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++)
                weights[i][j] = 16'(i + j);
    endtask

    task automatic set_w_all(input int v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++)
                weights[i][j] = 16'(v);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".in_ready"}, in_ready, 3'b111);
        chk({tag, ".out_valid"}, out_valid, 3'b000);
        chk({tag, ".sat"}, sat, 3'b000);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s.out_vec%0d", tag, k), out_vec[k], '0);
            chk($sformatf("%s.pred%0d", tag, k), pred[k], '0);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e0, input exp_t e1, input exp_t e2);
        chk($sformatf("%s.vec0", tag), out_vec[0], e0.vec);
        chk($sformatf("%s.vec1", tag), out_vec[1], e1.vec);
        chk($sformatf("%s.vec2", tag), out_vec[2], e2.vec);
        chk($sformatf("%s.pred", tag), {pred[2], pred[1], pred[0]}, {e2.pred, e1.pred, e0.pred});
        chk($sformatf("%s.sat", tag), sat, {e2.sat, e1.sat, e0.sat});
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send();
        int w;
        in_valid = 1'b1;
        w = 0;
        while (in_ready !== 3'b111 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", in_ready, 3'b111);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for the result, optionally holds backpressure while offering nxt.
    task automatic recv(input string tag, input int bp, input vin_t nxt);
        int   lat;
        exp_t e0, e1, e2;
        lat = 0;
        while (out_valid !== 3'b111 && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, 12);
        chk({tag, ".sb_pending"}, (q0.size() > 0) && (q1.size() > 0) && (q2.size() > 0), 1);
        e0 = (q0.size() > 0) ? q0.pop_front() : '0;
        e1 = (q1.size() > 0) ? q1.pop_front() : '0;
        e2 = (q2.size() > 0) ? q2.pop_front() : '0;
        if (bp > 0) begin
            in_valid = 1'b1;
            in_vec   = nxt;
        end
        for (int c = 0; c < bp; c++) begin
            chk_out($sformatf("%s.hold%0d", tag, c), e0, e1, e2);
            chk($sformatf("%s.hold%0d.in_ready", tag, c), in_ready, 3'b000);
            chk($sformatf("%s.hold%0d.out_valid", tag, c), out_valid, 3'b111);
            @(posedge clk);
            @(negedge clk);
        end
        chk_out(tag, e0, e1, e2);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".post_out_valid"}, out_valid, 3'b000);
        chk({tag, ".post_in_ready"}, in_ready, 3'b111);
    endtask

    initial begin
        vin_t vb;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        @(negedge clk);

        set_in(1, 2, 3, 4);
        set_w_inc();
        push3(mk(20, 30, 40, 2, 0), mk(20, 30, 40, 2, 0), mk(0, 0, 0, 0, 0));
        send();
        recv("basic", 0, '0);

        set_w_all(-1);
        push3(mk(0, 0, 0, 0, 0), mk(-10, -10, -10, 0, 0), mk(-1, -1, -1, 0, 0));
        send();
        recv("neg_tie", 0, '0);

        set_in(32767, 32767, 32767, 32767);
        set_w_all(32767);
        push3(mk(32767, 32767, 32767, 0, 1), mk(32767, 32767, 32767, 0, 1), mk(32767, 32767, 32767, 0, 1));
        send();
        recv("sat_hi", 0, '0);

        set_in(1, 2, 3, 4);
        set_w_inc();
        push3(mk(20, 30, 40, 2, 0), mk(20, 30, 40, 2, 0), mk(0, 0, 0, 0, 0));
        send();
        recv("sat_clear", 0, '0);

        set_in(256, 512, 0, 0);
        weights = '0;
        for (int j = 0; j < 3; j++) begin
            weights[0][j] = 16'(256 * (j + 1));
            weights[1][j] = 16'(-256);
        end
        push3(mk(0, 0, 32767, 2, 1), mk(-32768, 0, 32767, 2, 1), mk(-256, 0, 256, 2, 0));
        send();
        recv("frac", 0, '0);

        set_in(1, 2, 3, 4);
        set_w_inc();
        vb[0] = 16'd5; vb[1] = 16'd6; vb[2] = 16'd7; vb[3] = 16'd8;
        push3(mk(20, 30, 40, 2, 0), mk(20, 30, 40, 2, 0), mk(0, 0, 0, 0, 0));
        send();
        recv("bp", 5, vb);
        push3(mk(44, 70, 96, 2, 0), mk(44, 70, 96, 2, 0), mk(0, 0, 0, 0, 0));
        send();
        recv("after_bp", 0, '0);

        set_in(1, 2, 3, 4);
        push3(mk(20, 30, 40, 2, 0), mk(20, 30, 40, 2, 0), mk(0, 0, 0, 0, 0));
        send();
        repeat (6) @(negedge clk);
        chk("mac_busy", in_ready, 3'b000);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_mac_rst");
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push3(mk(20, 30, 40, 2, 0), mk(20, 30, 40, 2, 0), mk(0, 0, 0, 0, 0));
        send();
        recv("post_rst", 0, '0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                in_vec[i] = 16'($urandom);
                for (int j = 0; j < 3; j++) weights[i][j] = 16'($urandom);
            end
            push3(model(in_vec, weights, 1'b1, 0), model(in_vec, weights, 1'b0, 0),
                  model(in_vec, weights, 1'b0, 8));
            send();
            recv($sformatf("rand%0d", r), 0, '0);
        end

        chk("sb_drained", q0.size() + q1.size() + q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
